// File: rtl/inv_mix_columns_seq_if.sv
// Handshake bundle for the (Inv)MixColumns engine; master drives the input state, slave is the engine.
// Optional AES_FWD_MIXCOL_EN adds the mode select carried with the input state.
interface inv_mix_columns_seq_if;
  // A transfer happens on a rising edge where valid && ready; the source holds data stable
  // until then, and ready never depends combinationally on valid.
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef AES_FWD_MIXCOL_EN
  logic         mode;

  modport master (output in_valid, in_data, out_ready, mode,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready, mode,
                  output in_ready, out_valid, out_data);
`else
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns engine, COLS_PER_CYCLE columns per BUSY cycle.
// Define AES_FWD_MIXCOL_EN to add a forward MixColumns mode selected at accept time.
module inv_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inv_mix_columns_seq_if.slave  bus,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] CNT_STEP = 3'(COLS_PER_CYCLE);

  state_e       r_state;
  logic [2:0]   r_col_cnt;
  logic [127:0] r_work;
`ifdef AES_FWD_MIXCOL_EN
  logic         r_mode;
`endif

  logic [31:0]  w_cols    [4];
  logic [1:0]   w_idx     [COLS_PER_CYCLE];
  logic [31:0]  w_col_in  [COLS_PER_CYCLE];
  logic [31:0]  w_col_out [COLS_PER_CYCLE];
  logic [127:0] w_work_nxt;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ ({8{a[7]}} & 8'h1b);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] col);
    logic [7:0]  a [4];
    logic [7:0]  x2, x4, x8;
    logic [7:0]  m0e [4];
    logic [7:0]  m0b [4];
    logic [7:0]  m0d [4];
    logic [7:0]  m09 [4];
    logic [31:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      a[r]   = col[31-8*r -: 8];
      x2     = xtime(a[r]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m0e[r] = x8 ^ x4 ^ x2;
      m0b[r] = x8 ^ x2 ^ a[r];
      m0d[r] = x8 ^ x4 ^ a[r];
      m09[r] = x8 ^ a[r];
    end
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = m0e[r] ^ m0b[(r+1)%4] ^ m0d[(r+2)%4] ^ m09[(r+3)%4];
    end
    return res;
  endfunction

`ifdef AES_FWD_MIXCOL_EN
  function automatic logic [31:0] fwd_col(input logic [31:0] col);
    logic [7:0]  a  [4];
    logic [7:0]  m2 [4];
    logic [31:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      m2[r] = xtime(a[r]);
    end
    // 03*a = 02*a ^ a
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = m2[r] ^ m2[(r+1)%4] ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return res;
  endfunction
`endif

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_cols[c] = r_work[127-32*c -: 32];
    end
  end

  // Gather the columns handled this cycle, transform them, and scatter them back.
  always_comb begin
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      w_idx[k]    = r_col_cnt[1:0] + 2'(k);
      w_col_in[k] = w_cols[w_idx[k]];
`ifdef AES_FWD_MIXCOL_EN
      w_col_out[k] = r_mode ? fwd_col(w_col_in[k]) : inv_col(w_col_in[k]);
`else
      w_col_out[k] = inv_col(w_col_in[k]);
`endif
    end
  end

  always_comb begin
    w_work_nxt = r_work;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (w_idx[k] == 2'(c)) begin
          w_work_nxt[127-32*c -: 32] = w_col_out[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_col_cnt <= '0;
      r_work    <= '0;
`ifdef AES_FWD_MIXCOL_EN
      r_mode    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_work    <= bus.in_data;
            r_col_cnt <= '0;
            r_state   <= BUSY;
`ifdef AES_FWD_MIXCOL_EN
            r_mode    <= bus.mode;
`endif
          end
        end
        BUSY: begin
          r_work <= w_work_nxt;
          if (r_col_cnt + CNT_STEP == 3'd4) begin
            r_col_cnt <= '0;
            r_state   <= DONE;
          end else begin
            r_col_cnt <= r_col_cnt + CNT_STEP;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_data  = r_work;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq: GF(2^8) reference model, scoreboard queue, directed vectors.
// Define AES_FWD_MIXCOL_EN to also exercise the forward mode.
module tb_inv_mix_columns_seq;
  localparam int COLS = 1;
  localparam int LAT  = 4 / COLS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  inv_mix_columns_seq_if bus_if ();

  inv_mix_columns_seq #(.COLS_PER_CYCLE(COLS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if),
    .o_dbg_state (dbg_state)
  );

  int           errors = 0;
  int           checks = 0;
  longint       cycle = 0;
  logic [127:0] exp_q[$];
  bit           fwd_mode = 1'b0;
  bit           b2b_phase = 1'b0;
  longint       last_hs = -1;
  int           b2b_hs = 0;

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: generic shift-and-add GF(2^8) multiply, reduced by 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] model_mix(input logic [127:0] s, input bit fwd);
    logic [7:0]   coef [4];
    logic [7:0]   a    [4];
    logic [7:0]   acc;
    logic [127:0] r;
    r = '0;
    if (fwd) begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end else begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) a[rr] = s[127-32*c-8*rr -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[k], a[(rr+k)%4]);
        r[127-32*c-8*rr -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rep4(input logic [31:0] col);
    return {4{col}};
  endfunction

  // Output scoreboard: every accepted result is compared against the expected queue.
  always @(negedge clk) begin
    if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", bus_if.out_data);
      end else begin
        check("out_data", bus_if.out_data, exp_q.pop_front());
      end
      if (b2b_phase) begin
        if (last_hs >= 0) check("b2b_spacing", 128'(cycle - last_hs), 128'(LAT + 2));
        last_hs = cycle;
        b2b_hs++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [127:0] d, input bit push, input logic [127:0] e);
    int n;
    n = 0;
    if (push) exp_q.push_back(e);
`ifdef AES_FWD_MIXCOL_EN
    bus_if.mode = fwd_mode;
`endif
    bus_if.in_data  = d;
    bus_if.in_valid = 1'b1;
    while (!bus_if.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
      bus_if.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus_if.in_ready) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  logic [127:0] fips_in  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  logic [127:0] fips_out = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  logic [31:0]  col_in  [4] = '{32'h8e4da1bc, 32'h9fdc589d, 32'hc6c6c6c6, 32'h01010101};
  logic [31:0]  col_out [4] = '{32'hdb135345, 32'hf20a225c, 32'hc6c6c6c6, 32'h01010101};

  initial begin
    logic [127:0] snap;
    logic [127:0] v;
    int           n;

    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;
`ifdef AES_FWD_MIXCOL_EN
    bus_if.mode      = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(bus_if.in_ready), 128'd1);
    check("rst_out_valid", 128'(bus_if.out_valid), 128'd0);
    check("rst_out_data", bus_if.out_data, 128'd0);
    check("rst_state", 128'(dbg_state), 128'd0);
    rst_n = 1'b1;

    // Pin the model with hand-computed vectors.
    for (int i = 0; i < 4; i++) check("model_pin_col", model_mix(rep4(col_in[i]), 1'b0), rep4(col_out[i]));
    check("model_pin_fips", model_mix(fips_in, 1'b0), fips_out);

    // Column vectors, all four columns identical.
    @(posedge clk); #1;
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(rep4(col_in[i]), 1'b1, model_mix(rep4(col_in[i]), 1'b0));
    wait_drain();

    // FIPS round: latency, then backpressure with a second request pending.
    bus_if.out_ready = 1'b0;
    send(fips_in, 1'b1, model_mix(fips_in, 1'b0));
    n = 0;
    while (!bus_if.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 128'(n), 128'(LAT));
    check("fips_result", bus_if.out_data, fips_out);
    v = rep4(32'hc6c6c6c6);
    exp_q.push_back(model_mix(v, 1'b0));
    bus_if.in_data  = v;
    bus_if.in_valid = 1'b1;
    snap = bus_if.out_data;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 128'(bus_if.out_valid), 128'd1);
      check("bp_out_data", bus_if.out_data, snap);
      check("bp_in_ready", 128'(bus_if.in_ready), 128'd0);
    end
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_in_ready", 128'(bus_if.in_ready), 128'd1);
    check("post_hs_out_valid", 128'(bus_if.out_valid), 128'd0);
    @(posedge clk); #1;
    check("second_accept_busy", 128'(dbg_state), 128'd1);
    bus_if.in_valid = 1'b0;
    wait_drain();

    // Back-to-back: in_valid and out_ready held high across 8 blocks.
    b2b_phase = 1'b1;
    last_hs   = -1;
    b2b_hs    = 0;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: v = fips_in;
        1: v = rep4(col_in[0]);
        2: v = 128'h00112233_44556677_8899aabb_ccddeeff;
        3: v = rep4(col_in[1]);
        4: v = 128'hffffffff_00000000_80808080_01020408;
        5: v = fips_out;
        6: v = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        default: v = 128'hdeadbeef_cafef00d_13579bdf_2468ace0;
      endcase
      send(v, 1'b1, model_mix(v, 1'b0));
    end
    wait_drain();
    b2b_phase = 1'b0;
    check("b2b_count", 128'(b2b_hs), 128'd8);

    // Asynchronous reset in the middle of BUSY discards the block.
    bus_if.out_ready = 1'b0;
    send(fips_in, 1'b0, '0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 128'(bus_if.in_ready), 128'd1);
    check("mid_rst_out_valid", 128'(bus_if.out_valid), 128'd0);
    check("mid_rst_out_data", bus_if.out_data, 128'd0);
    check("mid_rst_state", 128'(dbg_state), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_if.out_ready = 1'b1;
    send(rep4(col_in[1]), 1'b1, model_mix(rep4(col_in[1]), 1'b0));
    wait_drain();

`ifdef AES_FWD_MIXCOL_EN
    check("model_pin_fwd", model_mix(rep4(32'hdb135345), 1'b1), rep4(32'h8e4da1bc));
    fwd_mode = 1'b1;
    send(rep4(32'hdb135345), 1'b1, rep4(32'h8e4da1bc));
    for (int i = 0; i < 1000; i++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      snap = model_mix(v, 1'b1);
      fwd_mode = 1'b1;
      send(v, 1'b1, snap);
      fwd_mode = 1'b0;
      send(snap, 1'b1, v);
    end
    wait_drain();
`endif

    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
